stream_mod_router: RTL and testbench

- Parametrised successor of the divisible/non-divisible stream splitter.
- Accepts one input stream, computes key mod divisor on the low KEY_W bits of each word, and routes the whole word to one of NUM_OUT output streams.
- Each output channel has its own FIFO buffer.
- Single clock domain; configured through a simple register port driven by the bus glue.

---
 rtl/stream_router_pkg.sv | 18 +
 rtl/stream_fifo.sv | 64 ++++++
 rtl/stream_mod_router.sv | 158 +++++++++++++++
 tb/tb_stream_mod_router.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_router_pkg.sv
// Shared constants for the modulo stream router: register addresses,
// control register bit positions and routing mode encodings.
package stream_router_pkg;

    localparam logic [7:0] ADDR_DIVISOR    = 8'h00;
    localparam logic [7:0] ADDR_CTRL       = 8'h01;
    localparam logic [7:0] ADDR_STATS_BASE = 8'h10;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_MODE  = 1;
    localparam int CTRL_FLUSH = 2;

    typedef enum logic {
        MODE_SPLIT  = 1'b0,
        MODE_SPREAD = 1'b1
    } route_mode_e;

endpackage

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO for one router output channel.
// The head word is driven straight from storage, so a word pushed on one
// edge is visible on o_dout the following cycle. Output reads zero when empty.
module stream_fifo #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_full,
    output logic              o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_FULL);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];

    // Pointer and occupancy tracking; flush discards everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Word storage; contents are don't-care until the slot is pushed.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/stream_mod_router.sv
// Modulo stream router: routes each input word to one of NUM_OUT buffered
// output channels according to (key mod divisor), key = si_data[KEY_W-1:0].
// Optional per-channel push counters are built when STREAM_ROUTER_STATS_EN
// is defined; otherwise their addresses read zero and writes are ignored.
module stream_mod_router
    import stream_router_pkg::*;
#(
    parameter int DATA_W     = 128,
    parameter int KEY_W      = 4,
    parameter int NUM_OUT    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_wr,
    input  logic [7:0]                cfg_addr,
    input  logic [31:0]               cfg_wdata,
    output logic [31:0]               cfg_rdata,
    input  logic                      si_valid,
    output logic                      si_rdy,
    input  logic [DATA_W-1:0]         si_data,
    output logic [NUM_OUT-1:0]        so_valid,
    input  logic [NUM_OUT-1:0]        so_rdy,
    output logic [NUM_OUT*DATA_W-1:0] so_data
);

    localparam int CH_W = $clog2(NUM_OUT);

    logic [KEY_W-1:0]   r_divisor;
    logic               r_enable;
    route_mode_e        r_mode;

    logic [KEY_W-1:0]   w_key;
    logic [KEY_W-1:0]   w_rem;
    logic [CH_W-1:0]    w_tgt;
    logic               w_wr_div;
    logic               w_wr_ctrl;
    logic               w_flush;
    logic               w_accept;
    logic [NUM_OUT-1:0] w_push;
    logic [NUM_OUT-1:0] w_full;
    logic [NUM_OUT-1:0] w_empty;
    logic               w_unused_wdata;

    assign w_key     = si_data[KEY_W-1:0];
    assign w_wr_div  = cfg_wr & (cfg_addr == ADDR_DIVISOR);
    assign w_wr_ctrl = cfg_wr & (cfg_addr == ADDR_CTRL);
    assign w_flush   = w_wr_ctrl & cfg_wdata[CTRL_FLUSH];

    // Only a handful of write-data bits are meaningful; the rest are ignored.
    assign w_unused_wdata = ^cfg_wdata;

    // Configuration registers; a write lands on the next edge so a word
    // accepted alongside a divisor write still sees the old divisor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_divisor <= '0;
            r_enable  <= 1'b0;
            r_mode    <= MODE_SPLIT;
        end else begin
            if (w_wr_div) r_divisor <= cfg_wdata[KEY_W-1:0];
            if (w_wr_ctrl) begin
                r_enable <= cfg_wdata[CTRL_EN];
                r_mode   <= route_mode_e'(cfg_wdata[CTRL_MODE]);
            end
        end
    end

    // Remainder of the key; a zero divisor passes the key through untouched.
    always_comb begin
        if (r_divisor == '0) w_rem = w_key;
        else                 w_rem = w_key % r_divisor;
    end

    // Channel selection: split uses channels 0/1, spread clamps to the last channel.
    always_comb begin
        w_tgt = '0;
        if (r_mode == MODE_SPLIT) begin
            w_tgt = (w_rem == '0) ? '0 : CH_W'(1);
        end else if (32'(w_rem) < NUM_OUT) begin
            w_tgt = CH_W'(w_rem);
        end else begin
            w_tgt = CH_W'(NUM_OUT - 1);
        end
    end

    // Ready never looks at so_rdy: a full target stalls the input even if a
    // pop would free a slot this very cycle.
    assign si_rdy   = r_enable & ~w_flush & ~w_full[w_tgt];
    assign w_accept = si_valid & si_rdy;

    // One-hot push strobe toward the selected channel.
    always_comb begin
        w_push = '0;
        if (w_accept) w_push[w_tgt] = 1'b1;
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_ch
        stream_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_flush (w_flush),
            .i_push  (w_push[g]),
            .i_din   (si_data),
            .i_pop   (so_rdy[g]),
            .o_dout  (so_data[g*DATA_W +: DATA_W]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g])
        );
    end

    assign so_valid = ~w_empty;

`ifdef STREAM_ROUTER_STATS_EN
    logic [31:0]        r_stat [NUM_OUT];
    logic [NUM_OUT-1:0] w_stat_clr;

    // Decode of counter-clear writes.
    always_comb begin
        w_stat_clr = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            w_stat_clr[i] = cfg_wr & (cfg_addr == ADDR_STATS_BASE + 8'(i));
        end
    end

    // Push counters; a clear wins over a coincident push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OUT; i++) r_stat[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (w_stat_clr[i])   r_stat[i] <= '0;
                else if (w_push[i])  r_stat[i] <= r_stat[i] + 32'd1;
            end
        end
    end
`endif

    // Register read mux; anything unmapped reads zero.
    always_comb begin
        cfg_rdata = '0;
        if (cfg_addr == ADDR_DIVISOR) begin
            cfg_rdata[KEY_W-1:0] = r_divisor;
        end else if (cfg_addr == ADDR_CTRL) begin
            cfg_rdata[CTRL_EN]   = r_enable;
            cfg_rdata[CTRL_MODE] = (r_mode == MODE_SPREAD);
        end
`ifdef STREAM_ROUTER_STATS_EN
        for (int i = 0; i < NUM_OUT; i++) begin
            if (cfg_addr == ADDR_STATS_BASE + 8'(i)) cfg_rdata = r_stat[i];
        end
`endif
    end

endmodule

// File: tb/tb_stream_mod_router.sv
// Bench for stream_mod_router: queue-based reference model compared every
// cycle, directed scenarios with hand-computed expectations, then random traffic.
module tb_stream_mod_router;

    localparam int DATA_W     = 128;
    localparam int KEY_W      = 4;
    localparam int NUM_OUT    = 4;
    localparam int FIFO_DEPTH = 8;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      cfg_wr;
    logic [7:0]                cfg_addr;
    logic [31:0]               cfg_wdata;
    logic [31:0]               cfg_rdata;
    logic                      si_valid;
    logic                      si_rdy;
    logic [DATA_W-1:0]         si_data;
    logic [NUM_OUT-1:0]        so_valid;
    logic [NUM_OUT-1:0]        so_rdy;
    logic [NUM_OUT*DATA_W-1:0] so_data;

    int checks   = 0;
    int failures = 0;

    stream_mod_router #(
        .DATA_W     (DATA_W),
        .KEY_W      (KEY_W),
        .NUM_OUT    (NUM_OUT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_wr    (cfg_wr),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .si_valid  (si_valid),
        .si_rdy    (si_rdy),
        .si_data   (si_data),
        .so_valid  (so_valid),
        .so_rdy    (so_rdy),
        .so_data   (so_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [KEY_W-1:0]  m_div;
    logic              m_en;
    logic              m_mode;
    logic [31:0]       m_stat [NUM_OUT];
    logic [DATA_W-1:0] mq   [NUM_OUT][$];
    logic [DATA_W-1:0] plog [NUM_OUT][$];
    int                m_ch;
    logic              m_fl;
    logic              m_rdy;
    int                m_a;

    function automatic int route(input logic [KEY_W-1:0] key);
        int rem;
        rem = (m_div == '0) ? int'(key) : int'(key) % int'(m_div);
        if (!m_mode) return (rem == 0) ? 0 : 1;
        return (rem < NUM_OUT) ? rem : NUM_OUT - 1;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [7:0] addr);
        int a;
        a = int'(addr);
        if (a == 0) return 32'(m_div);
        if (a == 1) return {30'd0, m_mode, m_en};
`ifdef STREAM_ROUTER_STATS_EN
        if (a >= 16 && a < 16 + NUM_OUT) return m_stat[a - 16];
`endif
        return 32'd0;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            m_div  = '0;
            m_en   = 1'b0;
            m_mode = 1'b0;
            for (int i = 0; i < NUM_OUT; i++) begin
                mq[i].delete();
                m_stat[i] = 32'd0;
            end
        end
        for (int i = 0; i < NUM_OUT; i++) begin
            chk("so_valid", 128'(so_valid[i]), 128'(mq[i].size() != 0));
            chk("so_data", so_data[i*DATA_W +: DATA_W], (mq[i].size() != 0) ? mq[i][0] : '0);
        end
        m_ch  = route(si_data[KEY_W-1:0]);
        m_fl  = cfg_wr && (cfg_addr == 8'h01) && cfg_wdata[2];
        m_rdy = rst_n && m_en && !m_fl && (mq[m_ch].size() < FIFO_DEPTH);
        chk("si_rdy", 128'(si_rdy), 128'(m_rdy));
        chk("cfg_rdata", 128'(cfg_rdata), 128'(exp_rd(cfg_addr)));
        if (rst_n) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (mq[i].size() != 0 && so_rdy[i]) plog[i].push_back(mq[i].pop_front());
            end
            if (si_valid && m_rdy) begin
                mq[m_ch].push_back(si_data);
                m_stat[m_ch] = m_stat[m_ch] + 32'd1;
            end
            if (cfg_wr) begin
                m_a = int'(cfg_addr);
                if (m_a == 0) begin
                    m_div = cfg_wdata[KEY_W-1:0];
                end else if (m_a == 1) begin
                    m_en   = cfg_wdata[0];
                    m_mode = cfg_wdata[1];
                    if (cfg_wdata[2]) for (int i = 0; i < NUM_OUT; i++) mq[i].delete();
                end else if (m_a >= 16 && m_a < 16 + NUM_OUT) begin
                    m_stat[m_a - 16] = 32'd0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [DATA_W-1:0] mk(input int k);
        logic [DATA_W-1:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        w[KEY_W-1:0] = KEY_W'(k);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
        cfg_wr    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_wr    = 1'b0;
        cfg_addr  = 8'h01;
    endtask

    task automatic send(input logic [DATA_W-1:0] w);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        si_valid = 1'b1;
        si_data  = w;
        while (!acc && n < 40) begin
            @(negedge clk);
            acc = si_rdy;
            tick();
            n++;
        end
        si_valid = 1'b0;
        if (!acc) chk("send_timeout", 128'(acc), 128'(1));
    endtask

    task automatic clear_logs();
        for (int i = 0; i < NUM_OUT; i++) plog[i].delete();
    endtask

    task automatic chk_keys(input string name, input int c, input int ek[$]);
        chk({name, "_cnt"}, 128'(plog[c].size()), 128'(ek.size()));
        for (int j = 0; j < ek.size() && j < plog[c].size(); j++) begin
            chk({name, "_key"}, 128'(plog[c][j][KEY_W-1:0]), 128'(ek[j]));
        end
    endtask

    task automatic read_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
        cfg_addr = a;
        #1;
        chk(name, 128'(cfg_rdata), 128'(exp));
        cfg_addr = 8'h01;
    endtask

    // ---------------- directed + random stimulus ----------------
    logic [7:0] rd_addrs [10] = '{8'h00, 8'h01, 8'h02, 8'h0F, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'hFF};
    logic [7:0] wr_addrs [7]  = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h12, 8'h13, 8'h20};

    initial begin
        int ek[$];
        logic [31:0] d;
        rst_n     = 1'b0;
        cfg_wr    = 1'b0;
        cfg_addr  = 8'h00;
        cfg_wdata = 32'd0;
        si_valid  = 1'b1;
        si_data   = mk(0);
        so_rdy    = '1;

        // Reset state
        idle(3);
        chk("rst_so_valid", 128'(so_valid), 128'(0));
        chk("rst_so_data", 128'(so_data[DATA_W-1:0]), 128'(0));
        chk("rst_si_rdy", 128'(si_rdy), 128'(0));
        read_chk("rst_div", 8'h00, 32'd0);
        si_valid = 1'b0;
        rst_n    = 1'b1;
        idle(2);

        // Split mode, divisor 3 (upper write bits must be dropped)
        cfg_write(8'h00, 32'hFFFF_FFF3);
        read_chk("div_read", 8'h00, 32'd3);
        cfg_write(8'h01, 32'h1);
        read_chk("ctrl_read", 8'h01, 32'h1);
        for (int i = 0; i < NUM_OUT; i++) cfg_write(8'h10 + 8'(i), 32'd0);
        clear_logs();
        for (int k = 0; k < 8; k++) send(mk(k));
        idle(4);
        ek = '{0, 3, 6};       chk_keys("split_ch0", 0, ek);
        ek = '{1, 2, 4, 5, 7}; chk_keys("split_ch1", 1, ek);
`ifdef STREAM_ROUTER_STATS_EN
        read_chk("stat0", 8'h10, 32'd3);
        read_chk("stat1", 8'h11, 32'd5);
`else
        read_chk("stat0", 8'h10, 32'd0);
        read_chk("stat1", 8'h11, 32'd0);
`endif
        cfg_write(8'h10, 32'h1234);
        read_chk("stat0_clr", 8'h10, 32'd0);

        // Backpressure / head-of-line blocking on channel 0
        clear_logs();
        so_rdy = 4'b1110;
        ek = '{0, 3, 6, 9, 12, 15, 0, 3};
        foreach (ek[j]) send(mk(ek[j]));
        si_valid = 1'b1;
        si_data  = mk(6);
        repeat (3) begin
            @(negedge clk);
            chk("hol_block", 128'(si_rdy), 128'(0));
            tick();
        end
        so_rdy = '1;
        @(negedge clk);
        chk("hol_still_full", 128'(si_rdy), 128'(0));
        tick();
        @(negedge clk);
        chk("hol_release", 128'(si_rdy), 128'(1));
        tick();
        si_valid = 1'b0;
        idle(12);
        ek = '{0, 3, 6, 9, 12, 15, 0, 3, 6}; chk_keys("hol_ch0", 0, ek);

        // Flush with five buffered words; the flush-cycle word is refused
        so_rdy = '0;
        for (int k = 0; k < 5; k++) send(mk(k));
        cfg_wr    = 1'b1;
        cfg_addr  = 8'h01;
        cfg_wdata = 32'h5;
        si_valid  = 1'b1;
        si_data   = mk(1);
        @(negedge clk);
        chk("flush_rdy", 128'(si_rdy), 128'(0));
        tick();
        cfg_wr   = 1'b0;
        si_valid = 1'b0;
        @(negedge clk);
        chk("flush_empty", 128'(so_valid), 128'(0));
        tick();
        so_rdy = '1;

        // Enable cleared while words are buffered: input stalls, outputs drain
        so_rdy = '0;
        send(mk(1));
        send(mk(2));
        cfg_write(8'h01, 32'h0);
        so_rdy   = '1;
        si_valid = 1'b1;
        si_data  = mk(0);
        @(negedge clk);
        chk("dis_rdy", 128'(si_rdy), 128'(0));
        chk("dis_drain", 128'(so_valid[1]), 128'(1));
        tick();
        si_valid = 1'b0;
        idle(4);

        // Spread mode, divisor 6, clamp to last channel
        cfg_write(8'h00, 32'd6);
        cfg_write(8'h01, 32'h3);
        clear_logs();
        send(mk(5));
        send(mk(4));
        send(mk(3));
        send(mk(11));
        send(mk(7));
        @(negedge clk);
        chk("lat_valid", 128'(so_valid[1]), 128'(1));
        chk("lat_key", 128'(so_data[DATA_W +: KEY_W]), 128'(7));
        tick();
        idle(4);
        ek = '{5, 4, 3, 11}; chk_keys("spread_ch3", 3, ek);
        ek = '{7};           chk_keys("spread_ch1", 1, ek);

        // Divisor 0 in spread: key passes through
        cfg_write(8'h00, 32'd0);
        clear_logs();
        send(mk(2));
        send(mk(9));
        idle(4);
        ek = '{2}; chk_keys("div0_ch2", 2, ek);
        ek = '{9}; chk_keys("div0_ch3", 3, ek);

        // Reset mid-operation drops buffered words
        so_rdy = '0;
        send(mk(1));
        send(mk(2));
        send(mk(3));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(so_valid), 128'(0));
        chk("mid_rst_rdy", 128'(si_rdy), 128'(0));
        tick();
        rst_n = 1'b1;
        read_chk("mid_rst_ctrl", 8'h01, 32'd0);
        so_rdy = '1;

        // Random traffic with occasional register activity
        cfg_write(8'h00, 32'd5);
        cfg_write(8'h01, 32'h3);
        for (int n = 0; n < 2500; n++) begin
            si_valid = ($urandom_range(0, 3) != 0);
            si_data  = mk(int'($urandom_range(0, 15)));
            so_rdy   = NUM_OUT'($urandom);
            cfg_wr   = 1'b0;
            cfg_addr = rd_addrs[$urandom_range(0, 9)];
            if ($urandom_range(0, 99) < 5) begin
                cfg_wr    = 1'b1;
                cfg_addr  = wr_addrs[$urandom_range(0, 6)];
                d         = $urandom;
                if (cfg_addr == 8'h01) begin
                    d[0] = ($urandom_range(0, 4) != 0);
                    d[2] = ($urandom_range(0, 15) == 0);
                end
                cfg_wdata = d;
            end
            tick();
        end
        cfg_wr   = 1'b0;
        si_valid = 1'b0;
        so_rdy   = '1;
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t got=running exp=finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
